// File: rtl/countdown_timer_pkg.sv
// Shared types and digit limits for the MM:SS countdown timer.
package countdown_timer_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned UNITS_MAX = 9;
    localparam int unsigned TENS_MAX  = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage : countdown_timer_pkg

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit: clamped preset load, decrement on enable,
// reloads MAX and raises borrow when decremented from zero.
module bcd_down_digit
    import countdown_timer_pkg::*;
#(
    parameter int unsigned MAX = UNITS_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [DIGIT_W-1:0] load_val_i,
    input  logic               en_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               borrow_c
);

    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MAX);

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;

    // Next digit value: load (clamped to MAX) wins over decrement.
    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = (load_val_i > MAX_V) ? MAX_V : load_val_i;
        end else if (en_i) begin
            digit_d = (digit_q == '0) ? MAX_V : digit_q - DIGIT_W'(1);
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o  = digit_q;
    assign borrow_c = en_i && (digit_q == '0);

endmodule : bcd_down_digit

// File: rtl/countdown_timer.sv
// MM:SS countdown timer with start/pause/load control and BCD digit outputs.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned CLOCK_PERIOD = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_sec1,
    input  logic [DIGIT_W-1:0] load_sec2,
    input  logic [DIGIT_W-1:0] load_min1,
    input  logic [DIGIT_W-1:0] load_min2,
    output logic [DIGIT_W-1:0] sec1,
    output logic [DIGIT_W-1:0] sec2,
    output logic [DIGIT_W-1:0] min1,
    output logic [DIGIT_W-1:0] min2,
    output logic               running,
    output logic               expired,
    output logic               done_pulse
);

    localparam int unsigned         PRESC_W    = (CLOCK_PERIOD > 1) ? $clog2(CLOCK_PERIOD) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(CLOCK_PERIOD - 1);

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               running_q, running_d;
    logic               expired_q, expired_d;
    logic               done_pulse_q, done_pulse_d;

    logic               load_acc_c;
    logic               tick_c;
    logic               sec1_borrow_c, sec2_borrow_c, min1_borrow_c, min2_borrow_c;
    logic               time_nz_c;
    logic               last_sec_c;

    // One-second tick: last prescaler count in RUN, suppressed by a freezing pause.
    assign tick_c     = (state_q == ST_RUN) && !pause && (presc_q == PRESC_LAST);
    assign time_nz_c  = |{min2, min1, sec2, sec1};
    assign last_sec_c = (min2 == '0) && (min1 == '0) && (sec2 == '0)
                        && (sec1 == DIGIT_W'(1));

    // Next-state, prescaler and registered-output logic.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        load_acc_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    load_acc_c = 1'b1;
                    presc_d    = '0;
                end else if (start && time_nz_c) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
            end
            ST_RUN: begin
                if (pause) begin
                    state_d = ST_PAUSED;
                end else if (tick_c) begin
                    presc_d = '0;
                    // min2 borrow means an underflow below 00:00; stop rather than wrap.
                    if (last_sec_c || min2_borrow_c) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            ST_PAUSED: begin
                if (load) begin
                    load_acc_c = 1'b1;
                    presc_d    = '0;
                    state_d    = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (load) begin
                    load_acc_c = 1'b1;
                    presc_d    = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase

        running_d    = (state_d == ST_RUN);
        expired_d    = (state_d == ST_DONE);
        done_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // State, prescaler and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            running_q    <= 1'b0;
            expired_q    <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            running_q    <= running_d;
            expired_q    <= expired_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign running    = running_q;
    assign expired    = expired_q;
    assign done_pulse = done_pulse_q;

    // Borrow chain: sec units -> sec tens -> min units -> min tens.
    bcd_down_digit #(.MAX(UNITS_MAX)) u_sec1 (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (load_acc_c),
        .load_val_i (load_sec1),
        .en_i       (tick_c),
        .digit_o    (sec1),
        .borrow_c   (sec1_borrow_c)
    );

    bcd_down_digit #(.MAX(TENS_MAX)) u_sec2 (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (load_acc_c),
        .load_val_i (load_sec2),
        .en_i       (sec1_borrow_c),
        .digit_o    (sec2),
        .borrow_c   (sec2_borrow_c)
    );

    bcd_down_digit #(.MAX(UNITS_MAX)) u_min1 (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (load_acc_c),
        .load_val_i (load_min1),
        .en_i       (sec2_borrow_c),
        .digit_o    (min1),
        .borrow_c   (min1_borrow_c)
    );

    bcd_down_digit #(.MAX(TENS_MAX)) u_min2 (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (load_acc_c),
        .load_val_i (load_min2),
        .en_i       (min1_borrow_c),
        .digit_o    (min2),
        .borrow_c   (min2_borrow_c)
    );

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Directed scoreboard bench for countdown_timer with a 4-cycle second.
module tb_countdown_timer;

    localparam int unsigned CP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, pause, load;
    logic [3:0] load_sec1, load_sec2, load_min1, load_min2;
    logic [3:0] sec1, sec2, min1, min2;
    logic       running, expired, done_pulse;

    typedef struct {
        string       tag;
        logic [18:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    countdown_timer #(.CLOCK_PERIOD(CP)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .load       (load),
        .load_sec1  (load_sec1),
        .load_sec2  (load_sec2),
        .load_min1  (load_min1),
        .load_min2  (load_min2),
        .sec1       (sec1),
        .sec2       (sec2),
        .min1       (min1),
        .min2       (min2),
        .running    (running),
        .expired    (expired),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Seconds count -> {min tens, min units, sec tens, sec units}.
    function automatic logic [15:0] to_bcd(input int secs);
        int m;
        int s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic push(input string tag, input int secs, input bit r, input bit e, input bit d);
        exp_t x;
        x.tag = tag;
        x.val = {to_bcd(secs), r, e, d};
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t        x;
        logic [18:0] obs;
        obs = {min2, min1, sec2, sec1, running, expired, done_pulse};
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h expected <none>", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", x.tag, obs, x.val);
            end
        end
    endtask

    task automatic expect_now(input string tag, input int secs, input bit r, input bit e, input bit d);
        push(tag, secs, r, e, d);
        check_out();
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input bit s, input bit p, input bit l);
        start = s;
        pause = p;
        load  = l;
        cyc(1);
        start = 1'b0;
        pause = 1'b0;
        load  = 1'b0;
    endtask

    task automatic set_load(input int secs);
        logic [15:0] b;
        b = to_bcd(secs);
        {load_min2, load_min1, load_sec2, load_sec1} = b;
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        load  = 1'b0;
        set_load(0);

        // Reset state
        cyc(2);
        expect_now("reset", 0, 0, 0, 0);
        rst = 1'b1;
        cyc(1);
        expect_now("post_reset", 0, 0, 0, 0);

        // 00:03 full countdown, one decrement every CP cycles
        set_load(3);
        pulse(0, 0, 1);
        expect_now("load_0003", 3, 0, 0, 0);
        pulse(1, 0, 0);
        expect_now("start_0003", 3, 1, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            for (int c = 1; c <= int'(CP); c++) begin
                if (c < int'(CP)) push("cnt_0003", 4 - k, 1, 0, 0);
                else              push("tick_0003", 3 - k, k < 3, k == 3, k == 3);
            end
        end
        for (int i = 0; i < 3 * int'(CP); i++) begin
            cyc(1);
            check_out();
        end
        cyc(1);
        expect_now("done_pulse_single", 0, 0, 1, 0);
        pulse(1, 0, 0);
        expect_now("start_in_done", 0, 0, 1, 0);

        // 01:00 -> 00:59 borrow across all lower digits
        set_load(60);
        pulse(0, 0, 1);
        expect_now("load_0100", 60, 0, 0, 0);
        pulse(1, 0, 0);
        expect_now("start_0100", 60, 1, 0, 0);
        cyc(3);
        expect_now("pre_borrow", 60, 1, 0, 0);
        cyc(1);
        expect_now("borrow_0059", 59, 1, 0, 0);
        pulse(0, 1, 0);
        expect_now("pause_0059", 59, 0, 0, 0);

        // Pause preserves prescaler; resume ticks 2 cycles later
        set_load(10);
        pulse(0, 0, 1);
        expect_now("load_0010", 10, 0, 0, 0);
        pulse(1, 0, 0);
        expect_now("start_0010", 10, 1, 0, 0);
        cyc(2);
        pulse(0, 1, 0);
        expect_now("pause_0010", 10, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            expect_now("frozen", 10, 0, 0, 0);
        end
        pulse(1, 0, 0);
        expect_now("resume", 10, 1, 0, 0);
        cyc(1);
        expect_now("resume_plus1", 10, 1, 0, 0);
        cyc(1);
        expect_now("resume_tick", 9, 1, 0, 0);

        // Coincident pulses: pause beats start in RUN; load beats start in PAUSED
        pulse(1, 1, 0);
        expect_now("start_pause_run", 9, 0, 0, 0);
        load_min2 = 4'd1;
        load_min1 = 4'd2;
        load_sec2 = 4'd3;
        load_sec1 = 4'd4;
        pulse(1, 0, 1);
        expect_now("load_start_paused", 12 * 60 + 34, 0, 0, 0);

        // Clamped 59:59, load ignored in RUN, full countdown
        load_min2 = 4'hF;
        load_min1 = 4'hF;
        load_sec2 = 4'hF;
        load_sec1 = 4'hF;
        pulse(0, 0, 1);
        expect_now("clamp_5959", 3599, 0, 0, 0);
        pulse(1, 0, 0);
        expect_now("start_5959", 3599, 1, 0, 0);
        set_load(5);
        pulse(0, 0, 1);
        expect_now("load_in_run", 3599, 1, 0, 0);
        cyc(2);
        expect_now("pre_first_tick", 3599, 1, 0, 0);
        for (int k = 1; k <= 3599; k++) begin
            cyc(1);
            push("full_count", 3599 - k, k < 3599, k == 3599, k == 3599);
            check_out();
            if (k < 3599) cyc(int'(CP) - 1);
        end
        cyc(1);
        expect_now("full_done_hold", 0, 0, 1, 0);
        set_load(0);
        pulse(0, 0, 1);
        expect_now("load_0000", 0, 0, 0, 0);
        pulse(1, 0, 0);
        expect_now("start_at_zero", 0, 0, 0, 0);

        // Asynchronous reset mid-RUN
        set_load(30);
        pulse(0, 0, 1);
        expect_now("load_0030", 30, 0, 0, 0);
        pulse(1, 0, 0);
        expect_now("start_0030", 30, 1, 0, 0);
        cyc(2);
        expect_now("run_0030", 30, 1, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        expect_now("async_reset", 0, 0, 0, 0);
        cyc(1);
        expect_now("reset_held", 0, 0, 0, 0);
        #3;
        rst = 1'b1;
        cyc(1);
        expect_now("after_release", 0, 0, 0, 0);
        pulse(1, 0, 0);
        expect_now("start_after_reset", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_countdown_timer

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter CLOCK_PERIOD, default 50_000_000, meaning clk cycles per one-second tick (minimum 2).
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  synchronous one-cycle pulse, already debounced: begin/resume countdown.
REQ-005 SHALL have port pause  input  1  synchronous one-cycle pulse, already debounced: freeze countdown.
REQ-006 SHALL have port load  input  1  synchronous one-cycle pulse: preset time from load digits.
REQ-007 SHALL have ports load_sec1, load_sec2, load_min1, load_min2  input  4 each  BCD preset digits (sec units, sec tens, min units, min tens).
REQ-008 SHALL have ports sec1, sec2, min1, min2  output  4 each  current BCD time digits, registered.
REQ-009 SHALL have port running  output  1  high while in RUN.
REQ-010 SHALL have port expired  output  1  high while in DONE.
REQ-011 SHALL have port done_pulse  output  1  one-cycle pulse on the clock edge that enters DONE.

Function
REQ-012 SHALL implement states IDLE, RUN, PAUSED, DONE.
REQ-013 load in IDLE, PAUSED or DONE SHALL register load digits, clear prescaler, go to IDLE; load in RUN SHALL be ignored.
REQ-014 Loaded digits SHALL be clamped: units digits >9 -> 9, tens digits >5 -> 5.
REQ-015 start in IDLE with time nonzero SHALL go to RUN with prescaler cleared; with time 00:00 SHALL remain IDLE.
REQ-016 start in PAUSED SHALL go to RUN with prescaler value preserved; start in RUN or DONE SHALL be ignored.
REQ-017 pause in RUN SHALL go to PAUSED holding prescaler and digits; pause elsewhere SHALL be ignored.
REQ-018 Priority when pulses coincide SHALL be load > pause > start (load then evaluated per REQ-013).
REQ-019 In RUN, prescaler SHALL count 0..CLOCK_PERIOD-1 and wrap; tick SHALL occur in the cycle prescaler equals CLOCK_PERIOD-1.
REQ-020 On tick, time SHALL decrement by one second: sec1 9->0 borrowing sec2, sec2 5->0 borrowing min1, min1 9->0 borrowing min2; borrowing digit reloads 9 (units) or 5 (tens).
REQ-021 First decrement SHALL become visible on outputs exactly CLOCK_PERIOD cycles after the edge that accepted start from IDLE.
REQ-022 The tick that yields 00:00 SHALL move to DONE on the same edge, asserting expired and done_pulse; no further decrement, no wrap to 59:59.
REQ-023 DONE SHALL persist until load or reset; digits remain 00:00.
REQ-024 Maximum preset 59:59 SHALL count down fully to 00:00 in 3599 ticks.

Reset
REQ-025 rst low SHALL asynchronously force state IDLE, prescaler 0, all digits 0, running 0, expired 0, done_pulse 0.
REQ-026 Reset asserted mid-countdown SHALL discard time; after release, start with no load SHALL be ignored (time 00:00).

Structure
REQ-027 Shared package SHALL hold the state enumeration and digit limit constants (UNITS_MAX=9, TENS_MAX=5).
REQ-028 One sub-module bcd_down_digit SHALL be instanced four times: parameter MAX, inputs load/load value/borrow-in enable, outputs digit and borrow-out (digit==0 and enabled).
REQ-029 Outputs SHALL be directly compatible with the team's existing BCD-to-seven-segment decoder.

Verification (CLOCK_PERIOD=4)
REQ-030 load 00:03, start -> decrements every 4 cycles to 00:00; expired high, done_pulse exactly one cycle, running low.
REQ-031 load 01:00, start, one tick -> digits 00:59 (borrow across min1/sec2/sec1).
REQ-032 start, 2 cycles, pause, wait 20 cycles, start -> next decrement 2 cycles after resume; digits frozen while PAUSED.
REQ-033 load 0xF:0xF:0xF:0xF -> digits 59:59; load during RUN -> ignored; start at 00:00 -> stays IDLE.
REQ-034 start and pause same cycle while RUN -> PAUSED; load+start same cycle in PAUSED -> IDLE with new digits.
REQ-035 rst low mid-RUN (asynchronous, between edges) -> outputs 0 immediately; after release, start -> no state change.
